// File: rtl/wordcount_pkg.sv
// wordcount_pkg
//   Shared constants for the word-count kernel: stream geometry, command
//   codes, FSM state encodings, delimiter byte values and a helper that
//   classifies a byte as a word delimiter.
package wordcount_pkg;

  localparam int DATA_W     = 512;
  localparam int ADDR_W     = 64;
  localparam int CNT_W      = 32;
  localparam int BEAT_BYTES = 64;

  localparam logic [31:0] CMD_COUNT = 32'd1;

  // FSM state encodings
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] RD_START  = 3'd1;
  localparam logic [2:0] RD_STREAM = 3'd2;
  localparam logic [2:0] RD_WAIT   = 3'd3;
  localparam logic [2:0] WR_START  = 3'd4;
  localparam logic [2:0] WR_DATA   = 3'd5;
  localparam logic [2:0] WR_WAIT   = 3'd6;
  localparam logic [2:0] DONE      = 3'd7;

  // Bytes that separate words
  localparam logic [7:0] DELIM_NUL = 8'h00;
  localparam logic [7:0] DELIM_TAB = 8'h09;
  localparam logic [7:0] DELIM_LF  = 8'h0A;
  localparam logic [7:0] DELIM_CR  = 8'h0D;
  localparam logic [7:0] DELIM_SP  = 8'h20;

  function automatic logic is_delim(input logic [7:0] b);
    return (b == DELIM_NUL) || (b == DELIM_TAB) || (b == DELIM_LF) ||
           (b == DELIM_CR)  || (b == DELIM_SP);
  endfunction

endpackage

// File: rtl/wordcount_beat_counter.sv
// wordcount_beat_counter
//   Purely combinational: counts word starts in one 64-byte beat.
//   Ports:
//     beat        in  512  beat bytes, byte 0 = [7:0] is first in text order
//     prev_delim  in  1    the byte before byte 0 was a delimiter
//     start_cnt   out 7    number of word starts in this beat (0..64)
//     last_delim  out 1    byte 63 of this beat is a delimiter
module wordcount_beat_counter
  import wordcount_pkg::*;
(
  input  logic [DATA_W-1:0] beat,
  input  logic              prev_delim,
  output logic [6:0]        start_cnt,
  output logic              last_delim
);

  logic [6:0] cnt;
  logic       pd;
  logic       cur_delim;

  // Walk the bytes in text order; a start is a non-delimiter whose
  // predecessor was a delimiter. pd carries the predecessor's class.
  always_comb begin
    cnt       = 7'd0;
    pd        = prev_delim;
    cur_delim = 1'b0;
    for (int i = 0; i < BEAT_BYTES; i++) begin
      cur_delim = is_delim(beat[i*8 +: 8]);
      if (!cur_delim && pd) begin
        cnt = cnt + 7'd1;
      end
      pd = cur_delim;
    end
    start_cnt  = cnt;
    last_delim = pd;
  end

endmodule

// File: rtl/wordcount_top.sv
// wordcount_top
//   Control and datapath core of the word-count kernel. A kick latches the
//   scalar arguments, the read master streams the text in, whitespace-
//   delimited words are counted, and one 512-bit result beat is written.
//   Result beat: [31:0] word count, [63:32] beats received, [95:64] busy
//   cycle count when WORDCOUNT_CYCLE_COUNTER_EN is defined (else 0), rest 0.
//   Ports:
//     clk, reset                      clock, synchronous active-high reset
//     kick / busy                     job start pulse / job in progress
//     command, num_of_words,
//     global_memory_offset            scalar job arguments
//     reader_ctrl_*                   read master start/done/address/size
//     reader_s_axis_*                 input text stream (tlast ignored)
//     writer_ctrl_*                   write master start/done/address/size
//     writer_m_axis_*                 result beat stream
module wordcount_top
  import wordcount_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              kick,
  output logic              busy,
  input  logic [31:0]       command,
  input  logic [31:0]       num_of_words,
  input  logic [ADDR_W-1:0] global_memory_offset,
  output logic              reader_ctrl_start,
  input  logic              reader_ctrl_done,
  output logic [ADDR_W-1:0] reader_ctrl_addr_offset,
  output logic [ADDR_W-1:0] reader_ctrl_xfer_size_in_bytes,
  input  logic              reader_s_axis_tvalid,
  output logic              reader_s_axis_tready,
  input  logic [DATA_W-1:0] reader_s_axis_tdata,
  input  logic              reader_s_axis_tlast,
  output logic              writer_ctrl_start,
  input  logic              writer_ctrl_done,
  output logic [ADDR_W-1:0] writer_ctrl_addr_offset,
  output logic [ADDR_W-1:0] writer_ctrl_xfer_size_in_bytes,
  output logic              writer_m_axis_tvalid,
  input  logic              writer_m_axis_tready,
  output logic [DATA_W-1:0] writer_m_axis_tdata
);

  logic [2:0]        state;
  logic [CNT_W-1:0]  nwords_q;
  logic [ADDR_W-1:0] offset_q;
  logic [CNT_W-1:0]  beats_rx;
  logic [CNT_W-1:0]  word_cnt;
  logic              prev_delim;
  logic              rd_done_seen;
  logic              wr_done_seen;
  logic [6:0]        beat_starts;
  logic              beat_last_delim;
  logic              beat_fire;
  logic [ADDR_W-1:0] in_bytes;
  logic [31:0]       cycle_field;
  logic              unused_tlast;

  // Termination is by beat count, so tlast carries no information here.
  assign unused_tlast = reader_s_axis_tlast;

  wordcount_beat_counter u_beat_counter (
    .beat       (reader_s_axis_tdata),
    .prev_delim (prev_delim),
    .start_cnt  (beat_starts),
    .last_delim (beat_last_delim)
  );

  assign in_bytes  = {26'd0, nwords_q, 6'd0};
  assign beat_fire = reader_s_axis_tvalid && reader_s_axis_tready;

  assign reader_ctrl_start              = (state == RD_START);
  assign reader_ctrl_addr_offset        = offset_q;
  assign reader_ctrl_xfer_size_in_bytes = in_bytes;
  assign reader_s_axis_tready           = (state == RD_STREAM) && (beats_rx < nwords_q);

  // The result is written right after the input text. Size outputs stay 0
  // out of reset since nwords_q/offset_q are cleared.
  assign writer_ctrl_start              = (state == WR_START);
  assign writer_ctrl_addr_offset        = offset_q + in_bytes;
  assign writer_ctrl_xfer_size_in_bytes = (state == IDLE && !busy && nwords_q == '0 && offset_q == '0)
                                          ? '0 : ADDR_W'(BEAT_BYTES);
  assign writer_m_axis_tvalid           = (state == WR_DATA);
  assign writer_m_axis_tdata            = {416'd0, cycle_field, beats_rx, word_cnt};

`ifdef WORDCOUNT_CYCLE_COUNTER_EN
  logic [31:0] cycle_cnt;

  // Counts every cycle the job is busy; restarts with each accepted kick.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt <= '0;
    end else if (state == IDLE && kick) begin
      cycle_cnt <= '0;
    end else if (busy) begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  assign cycle_field = cycle_cnt;
`else
  assign cycle_field = 32'd0;
`endif

  // Main job FSM. Done pulses from either master are remembered while a
  // job is active so an early done is still honoured in the wait states.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      nwords_q     <= '0;
      offset_q     <= '0;
      beats_rx     <= '0;
      word_cnt     <= '0;
      prev_delim   <= 1'b1;
      rd_done_seen <= 1'b0;
      wr_done_seen <= 1'b0;
    end else begin
      if (state != IDLE) begin
        if (reader_ctrl_done) rd_done_seen <= 1'b1;
        if (writer_ctrl_done) wr_done_seen <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (kick) begin
            nwords_q     <= num_of_words;
            offset_q     <= global_memory_offset;
            busy         <= 1'b1;
            beats_rx     <= '0;
            word_cnt     <= '0;
            prev_delim   <= 1'b1;
            rd_done_seen <= 1'b0;
            wr_done_seen <= 1'b0;
            if (command != CMD_COUNT) begin
              state <= DONE;
            end else if (num_of_words == '0) begin
              state <= WR_START;
            end else begin
              state <= RD_START;
            end
          end
        end
        RD_START: state <= RD_STREAM;
        RD_STREAM: begin
          if (beat_fire) begin
            beats_rx   <= beats_rx + 32'd1;
            word_cnt   <= word_cnt + {25'd0, beat_starts};
            prev_delim <= beat_last_delim;
            if (beats_rx + 32'd1 == nwords_q) begin
              state <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (reader_ctrl_done || rd_done_seen) state <= WR_START;
        end
        WR_START: state <= WR_DATA;
        WR_DATA: begin
          if (writer_m_axis_tready) state <= WR_WAIT;
        end
        WR_WAIT: begin
          if (writer_ctrl_done || wr_done_seen) state <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wordcount_top.sv
// tb_wordcount_top
//   Directed self-checking bench for wordcount_top. A cycle-level driver
//   plays read/write master shims; each test task compares what it saw
//   against hand-computed values.
module tb_wordcount_top;

  logic         clk;
  logic         reset;
  logic         kick;
  logic         busy;
  logic [31:0]  command;
  logic [31:0]  num_of_words;
  logic [63:0]  global_memory_offset;
  logic         reader_ctrl_start;
  logic         reader_ctrl_done;
  logic [63:0]  reader_ctrl_addr_offset;
  logic [63:0]  reader_ctrl_xfer_size_in_bytes;
  logic         reader_s_axis_tvalid;
  logic         reader_s_axis_tready;
  logic [511:0] reader_s_axis_tdata;
  logic         reader_s_axis_tlast;
  logic         writer_ctrl_start;
  logic         writer_ctrl_done;
  logic [63:0]  writer_ctrl_addr_offset;
  logic [63:0]  writer_ctrl_xfer_size_in_bytes;
  logic         writer_m_axis_tvalid;
  logic         writer_m_axis_tready;
  logic [511:0] writer_m_axis_tdata;

  wordcount_top dut (
    .clk                            (clk),
    .reset                          (reset),
    .kick                           (kick),
    .busy                           (busy),
    .command                        (command),
    .num_of_words                   (num_of_words),
    .global_memory_offset           (global_memory_offset),
    .reader_ctrl_start              (reader_ctrl_start),
    .reader_ctrl_done               (reader_ctrl_done),
    .reader_ctrl_addr_offset        (reader_ctrl_addr_offset),
    .reader_ctrl_xfer_size_in_bytes (reader_ctrl_xfer_size_in_bytes),
    .reader_s_axis_tvalid           (reader_s_axis_tvalid),
    .reader_s_axis_tready           (reader_s_axis_tready),
    .reader_s_axis_tdata            (reader_s_axis_tdata),
    .reader_s_axis_tlast            (reader_s_axis_tlast),
    .writer_ctrl_start              (writer_ctrl_start),
    .writer_ctrl_done               (writer_ctrl_done),
    .writer_ctrl_addr_offset        (writer_ctrl_addr_offset),
    .writer_ctrl_xfer_size_in_bytes (writer_ctrl_xfer_size_in_bytes),
    .writer_m_axis_tvalid           (writer_m_axis_tvalid),
    .writer_m_axis_tready           (writer_m_axis_tready),
    .writer_m_axis_tdata            (writer_m_axis_tdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run;
  int tests_failed;

  logic [511:0] beat_mem [0:127];

  // Observations captured by run_job
  int           obs_rd_starts;
  int           obs_wr_starts;
  int           obs_wr_valids;
  int           obs_busy_cycles;
  int           obs_beats;
  int           obs_extra_ready;
  bit           obs_timeout;
  logic [63:0]  obs_rd_addr;
  logic [63:0]  obs_rd_size;
  logic [63:0]  obs_wr_addr;
  logic [63:0]  obs_wr_size;
  logic [511:0] obs_tdata;

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1;
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
  endtask

  // Plays both master shims for one job. Inputs change and outputs are
  // sampled on the falling edge only.
  task automatic run_job(input logic [31:0] cmd, input logic [31:0] nw,
                         input logic [63:0] off, input bit early_done);
    int  beat_idx;
    bit  finished;
    bit  fire;
    bit  rd_done_sent;
    bit  wr_pending;
    bit  wr_done_sent;
    beat_idx = 0; finished = 0; rd_done_sent = 0; wr_pending = 0; wr_done_sent = 0;
    obs_rd_starts = 0; obs_wr_starts = 0; obs_wr_valids = 0; obs_busy_cycles = 0;
    obs_beats = 0; obs_extra_ready = 0; obs_timeout = 0;
    obs_rd_addr = '0; obs_rd_size = '0; obs_wr_addr = '0; obs_wr_size = '0; obs_tdata = '0;
    @(negedge clk);
    kick = 1'b1; command = cmd; num_of_words = nw; global_memory_offset = off;
    writer_m_axis_tready = 1'b1;
    @(negedge clk);
    kick = 1'b0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      if (!busy) begin
        finished = 1;
        break;
      end
      obs_busy_cycles++;
      reader_s_axis_tvalid = (beat_idx < int'(nw));
      reader_s_axis_tdata  = (beat_idx < 128) ? beat_mem[beat_idx] : '0;
      reader_ctrl_done = 1'b0;
      writer_ctrl_done = 1'b0;
      fire = reader_s_axis_tvalid && reader_s_axis_tready;
      if (reader_s_axis_tready && beat_idx >= int'(nw)) obs_extra_ready++;
      if (reader_ctrl_start) begin
        obs_rd_starts++;
        obs_rd_addr = reader_ctrl_addr_offset;
        obs_rd_size = reader_ctrl_xfer_size_in_bytes;
        if (early_done) begin
          reader_ctrl_done = 1'b1;
          rd_done_sent = 1;
        end
      end else if (!rd_done_sent && obs_rd_starts > 0 && beat_idx == int'(nw)) begin
        reader_ctrl_done = 1'b1;
        rd_done_sent = 1;
      end
      if (writer_ctrl_start) begin
        obs_wr_starts++;
        obs_wr_addr = writer_ctrl_addr_offset;
        obs_wr_size = writer_ctrl_xfer_size_in_bytes;
      end
      if (wr_pending && !wr_done_sent) begin
        writer_ctrl_done = 1'b1;
        wr_done_sent = 1;
      end
      if (writer_m_axis_tvalid) begin
        obs_wr_valids++;
        if (!wr_pending) begin
          obs_tdata = writer_m_axis_tdata;
          wr_pending = 1;
          if (early_done) begin
            writer_ctrl_done = 1'b1;
            wr_done_sent = 1;
          end
        end
      end
      @(negedge clk);
      if (fire) beat_idx++;
    end
    obs_beats = beat_idx;
    reader_s_axis_tvalid = 1'b0;
    reader_ctrl_done = 1'b0;
    writer_ctrl_done = 1'b0;
    if (!finished) begin
      obs_timeout = 1;
      do_reset(2);
    end
  endtask

  task automatic test_reset;
    logic others;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      others = |{reader_ctrl_start, reader_s_axis_tready, writer_ctrl_start,
                 writer_m_axis_tvalid, reader_ctrl_addr_offset,
                 reader_ctrl_xfer_size_in_bytes, writer_ctrl_addr_offset,
                 writer_ctrl_xfer_size_in_bytes, writer_m_axis_tdata};
      tests_run++;
      if (busy !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL reset_busy cycle %0d: got %b expected 0", i, busy);
      end
      tests_run++;
      if (others !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL reset_outputs cycle %0d: some output nonzero (%b) expected all 0", i, others);
      end
    end
    reset = 1'b0;
  endtask

  task automatic check_timeout(input string name);
    tests_run++;
    if (obs_timeout !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL %s_timeout: got busy stuck, expected job to finish", name);
    end
  endtask

  task automatic test_long_stream;
    logic [511:0] pat;
    pat = {{2{64'h0123456789abcdef}}, {4{32'hdeadbeef}}, {4{32'habadcafe}}, {4{32'h11c0ffee}}};
    for (int i = 0; i < 128; i++) beat_mem[i] = pat;
    run_job(32'd1, 32'd128, 64'h0000_0000_8000_0000, 1'b0);
    check_timeout("long");
    tests_run++;
    if (obs_rd_starts !== 1 || obs_rd_addr !== 64'h8000_0000) begin
      tests_failed++;
      $display("[TB] FAIL long_rd_addr: got starts=%0d addr=%h expected 1 / 80000000", obs_rd_starts, obs_rd_addr);
    end
    tests_run++;
    if (obs_rd_size !== 64'd8192) begin
      tests_failed++;
      $display("[TB] FAIL long_rd_size: got %0d expected 8192", obs_rd_size);
    end
    tests_run++;
    if (obs_wr_starts !== 1 || obs_wr_addr !== 64'h8000_2000) begin
      tests_failed++;
      $display("[TB] FAIL long_wr_addr: got starts=%0d addr=%h expected 1 / 80002000", obs_wr_starts, obs_wr_addr);
    end
    tests_run++;
    if (obs_wr_size !== 64'd64) begin
      tests_failed++;
      $display("[TB] FAIL long_wr_size: got %0d expected 64", obs_wr_size);
    end
    tests_run++;
    if (obs_tdata[63:0] !== {32'd128, 32'd1}) begin
      tests_failed++;
      $display("[TB] FAIL long_result: got %h expected %h", obs_tdata[63:0], {32'd128, 32'd1});
    end
    tests_run++;
`ifdef WORDCOUNT_CYCLE_COUNTER_EN
    if (obs_tdata[511:96] !== '0) begin
`else
    if (obs_tdata[511:64] !== '0) begin
`endif
      tests_failed++;
      $display("[TB] FAIL long_result_upper: got nonzero upper bits expected 0");
    end
    tests_run++;
    if (obs_beats !== 128 || obs_extra_ready !== 0) begin
      tests_failed++;
      $display("[TB] FAIL long_beats: got beats=%0d extra_ready=%0d expected 128 / 0", obs_beats, obs_extra_ready);
    end
  endtask

  task automatic load_text_beat;
    logic [511:0] b;
    b = '0;
    b[7:0] = 8'h61; b[15:8] = 8'h62; b[23:16] = 8'h20; b[31:24] = 8'h63;
    b[39:32] = 8'h64; b[47:40] = 8'h0A; b[55:48] = 8'h20; b[63:56] = 8'h65;
    beat_mem[0] = b;
  endtask

  task automatic test_short_text;
    load_text_beat();
    run_job(32'd1, 32'd1, 64'h0000_0000_0000_4000, 1'b0);
    check_timeout("short");
    tests_run++;
    if (obs_tdata[63:0] !== {32'd1, 32'd3}) begin
      tests_failed++;
      $display("[TB] FAIL short_result: got %h expected %h", obs_tdata[63:0], {32'd1, 32'd3});
    end
    tests_run++;
    if (obs_wr_addr !== 64'h4040 || obs_wr_valids !== 1) begin
      tests_failed++;
      $display("[TB] FAIL short_wr: got addr=%h valids=%0d expected 4040 / 1", obs_wr_addr, obs_wr_valids);
    end
  endtask

  task automatic test_boundary_early_done;
    logic [511:0] b;
    b = '0;
    b[511:504] = 8'h41;
    beat_mem[0] = b;
    b = '0;
    b[7:0] = 8'h42; b[15:8] = 8'h20; b[47:40] = 8'h43;
    beat_mem[1] = b;
    run_job(32'd1, 32'd2, 64'h0000_0000_0001_0000, 1'b1);
    check_timeout("boundary");
    tests_run++;
    if (obs_tdata[63:0] !== {32'd2, 32'd2}) begin
      tests_failed++;
      $display("[TB] FAIL boundary_result: got %h expected %h", obs_tdata[63:0], {32'd2, 32'd2});
    end
  endtask

  task automatic test_back_to_back;
    logic [511:0] pat;
    for (int i = 0; i < 64; i++) pat[i*8 +: 8] = (i % 2 == 0) ? 8'h61 : 8'h20;
    beat_mem[0] = pat;
    beat_mem[1] = pat;
    run_job(32'd1, 32'd2, 64'h0000_0000_0000_0000, 1'b0);
    check_timeout("b2b");
    tests_run++;
    if (obs_tdata[63:0] !== {32'd2, 32'd64}) begin
      tests_failed++;
      $display("[TB] FAIL b2b_alternating: got %h expected %h", obs_tdata[63:0], {32'd2, 32'd64});
    end
  endtask

  task automatic test_nop_and_empty;
    run_job(32'd0, 32'd5, 64'h1234, 1'b0);
    check_timeout("nop");
    tests_run++;
    if (obs_busy_cycles !== 1 || obs_rd_starts !== 0 || obs_wr_starts !== 0 || obs_wr_valids !== 0) begin
      tests_failed++;
      $display("[TB] FAIL nop: got busy=%0d rd=%0d wr=%0d valid=%0d expected 1/0/0/0",
               obs_busy_cycles, obs_rd_starts, obs_wr_starts, obs_wr_valids);
    end
    run_job(32'd1, 32'd0, 64'h0000_0000_0000_7700, 1'b0);
    check_timeout("empty");
    tests_run++;
    if (obs_rd_starts !== 0 || obs_wr_starts !== 1 || obs_wr_addr !== 64'h7700) begin
      tests_failed++;
      $display("[TB] FAIL empty_ctrl: got rd=%0d wr=%0d addr=%h expected 0/1/7700",
               obs_rd_starts, obs_wr_starts, obs_wr_addr);
    end
    tests_run++;
    if (obs_tdata[63:0] !== 64'd0) begin
      tests_failed++;
      $display("[TB] FAIL empty_result: got %h expected 0", obs_tdata[63:0]);
    end
  endtask

  task automatic test_reset_mid_stream;
    @(negedge clk);
    kick = 1'b1; command = 32'd1; num_of_words = 32'd4; global_memory_offset = 64'h1000;
    reader_s_axis_tvalid = 1'b0;
    @(negedge clk);
    kick = 1'b0;
    @(negedge clk);
    tests_run++;
    if (reader_s_axis_tready !== 1'b1 || busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL midreset_streaming: got tready=%b busy=%b expected 1/1", reader_s_axis_tready, busy);
    end
    reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if (reader_s_axis_tready !== 1'b0 || busy !== 1'b0 || reader_ctrl_addr_offset !== 64'd0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_idle: got tready=%b busy=%b addr=%h expected 0/0/0",
               reader_s_axis_tready, busy, reader_ctrl_addr_offset);
    end
    reset = 1'b0;
    load_text_beat();
    run_job(32'd1, 32'd1, 64'h0000_0000_0000_2000, 1'b0);
    check_timeout("after_reset");
    tests_run++;
    if (obs_tdata[63:0] !== {32'd1, 32'd3} || obs_wr_addr !== 64'h2040) begin
      tests_failed++;
      $display("[TB] FAIL after_reset_result: got %h addr=%h expected %h / 2040",
               obs_tdata[63:0], obs_wr_addr, {32'd1, 32'd3});
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    reset = 1'b1;
    kick = 1'b0;
    command = '0;
    num_of_words = '0;
    global_memory_offset = '0;
    reader_ctrl_done = 1'b0;
    reader_s_axis_tvalid = 1'b0;
    reader_s_axis_tdata = '0;
    reader_s_axis_tlast = 1'b0;
    writer_ctrl_done = 1'b0;
    writer_m_axis_tready = 1'b1;
    for (int i = 0; i < 128; i++) beat_mem[i] = '0;
    test_reset();
    test_long_stream();
    test_short_text();
    test_boundary_early_done();
    test_back_to_back();
    test_nop_and_empty();
    test_reset_mid_stream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
